// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  localparam logic [4:0]  REG_X0       = 5'd0;
  localparam logic [31:0] NOP_INSTR    = 32'h00000013;
  localparam int          IDEX_CTRL_W  = 7;
  localparam int          EXMEM_CTRL_W = 4;
  localparam int          MEMWB_CTRL_W = 1;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs from the pipeline and register/PC strobes back to it.
// The controller uses the slave modport; the pipeline datapath uses master.
interface pipe_hazard_ctrl_if;
  logic [4:0] id_rs1_i;
  logic [4:0] id_rs2_i;
  logic       ex_mem_read_i;
  logic [4:0] ex_rd_i;
  logic       mem_branch_i;
  logic       mem_zero_i;
  logic       dmem_busy_i;
  logic       pc_write_o;
  logic       pc_sel_o;
  logic       ifid_write_o;
  logic       ifid_flush_o;
  logic       idex_write_o;
  logic       idex_flush_o;
  logic       exmem_write_o;
  logic       exmem_flush_o;
  logic       memwb_write_o;
  logic       ctrl_busy_o;

  modport slave (
    input  id_rs1_i, id_rs2_i, ex_mem_read_i, ex_rd_i,
           mem_branch_i, mem_zero_i, dmem_busy_i,
    output pc_write_o, pc_sel_o, ifid_write_o, ifid_flush_o,
           idex_write_o, idex_flush_o, exmem_write_o, exmem_flush_o,
           memwb_write_o, ctrl_busy_o
  );

  modport master (
    output id_rs1_i, id_rs2_i, ex_mem_read_i, ex_rd_i,
           mem_branch_i, mem_zero_i, dmem_busy_i,
    input  pc_write_o, pc_sel_o, ifid_write_o, ifid_flush_o,
           idex_write_o, idex_flush_o, exmem_write_o, exmem_flush_o,
           memwb_write_o, ctrl_busy_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use detector: a load in EX feeding a source of the ID
// instruction. Writes to x0 are never a dependency.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  output logic       load_use_o
);

  assign load_use_o = ex_mem_read_i && (ex_rd_i != REG_X0) &&
                      ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register / PC sequencer: reset scrub, load-use bubbles, branch
// flushes and dmem freeze. Define PIPE_HAZARD_PERF_EN for perf counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int INIT_CYCLES = 4
`ifdef PIPE_HAZARD_PERF_EN
  , parameter int CNT_W     = 32
`endif
) (
  input  logic             clk_i,
  input  logic             rst_i,
`ifdef PIPE_HAZARD_PERF_EN
  output logic [CNT_W-1:0] perf_stall_o,
  output logic [CNT_W-1:0] perf_flush_o,
  output logic [CNT_W-1:0] perf_wait_o,
`endif
  pipe_hazard_ctrl_if.slave bus
);

  localparam int CW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load_use_s;
  logic          taken_s;

  hazard_detect u_hazard_detect (
    .ex_mem_read_i (bus.ex_mem_read_i),
    .ex_rd_i       (bus.ex_rd_i),
    .id_rs1_i      (bus.id_rs1_i),
    .id_rs2_i      (bus.id_rs2_i),
    .load_use_o    (load_use_s)
  );

  assign taken_s = bus.mem_branch_i && bus.mem_zero_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
      cnt_q   <= CW'(INIT_CYCLES - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    bus.pc_write_o    = 1'b0;
    bus.pc_sel_o      = 1'b0;
    bus.ifid_write_o  = 1'b0;
    bus.ifid_flush_o  = 1'b0;
    bus.idex_write_o  = 1'b0;
    bus.idex_flush_o  = 1'b0;
    bus.exmem_write_o = 1'b0;
    bus.exmem_flush_o = 1'b0;
    bus.memwb_write_o = 1'b0;
    bus.ctrl_busy_o   = 1'b0;

    // Reset and scrub both present the bubble-everything pattern.
    if (rst_i || (state_q == ST_INIT) ||
        ((state_q != ST_RUN) && (state_q != ST_WAIT))) begin
      bus.ifid_write_o  = 1'b1;
      bus.ifid_flush_o  = 1'b1;
      bus.idex_write_o  = 1'b1;
      bus.idex_flush_o  = 1'b1;
      bus.exmem_write_o = 1'b1;
      bus.exmem_flush_o = 1'b1;
      bus.memwb_write_o = 1'b1;
      bus.ctrl_busy_o   = 1'b1;
      if (state_q != ST_INIT) begin
        state_d = ST_INIT;
        cnt_d   = CW'(INIT_CYCLES - 1);
      end else if (cnt_q == CW'(0)) begin
        state_d = ST_RUN;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end else if (bus.dmem_busy_i) begin
      state_d = ST_WAIT;
    end else begin
      // RUN priorities; WAIT falls through here the cycle busy drops.
      state_d           = ST_RUN;
      bus.pc_write_o    = 1'b1;
      bus.ifid_write_o  = 1'b1;
      bus.idex_write_o  = 1'b1;
      bus.exmem_write_o = 1'b1;
      bus.memwb_write_o = 1'b1;
      if (taken_s) begin
        bus.pc_sel_o      = 1'b1;
        bus.ifid_flush_o  = 1'b1;
        bus.idex_flush_o  = 1'b1;
        bus.exmem_flush_o = 1'b1;
      end else if (load_use_s) begin
        bus.pc_write_o   = 1'b0;
        bus.ifid_write_o = 1'b0;
        bus.idex_flush_o = 1'b1;
      end else begin
        bus.pc_sel_o = 1'b0;
      end
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic active_s;
  logic ev_stall_s, ev_flush_s, ev_wait_s;

  assign active_s   = !rst_i && ((state_q == ST_RUN) || (state_q == ST_WAIT));
  assign ev_wait_s  = active_s && bus.dmem_busy_i;
  assign ev_flush_s = active_s && !bus.dmem_busy_i && taken_s;
  assign ev_stall_s = active_s && !bus.dmem_busy_i && !taken_s && load_use_s;

  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_stall_o <= '0;
      perf_flush_o <= '0;
      perf_wait_o  <= '0;
    end else begin
      if (ev_stall_s && (perf_stall_o != '1)) perf_stall_o <= perf_stall_o + CNT_W'(1);
      else                                    perf_stall_o <= perf_stall_o;
      if (ev_flush_s && (perf_flush_o != '1)) perf_flush_o <= perf_flush_o + CNT_W'(1);
      else                                    perf_flush_o <= perf_flush_o;
      if (ev_wait_s && (perf_wait_o != '1))   perf_wait_o  <= perf_wait_o + CNT_W'(1);
      else                                    perf_wait_o  <= perf_wait_o;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl; outputs packed as
// {busy, pc_write, pc_sel, ifid_w, ifid_f, idex_w, idex_f, exmem_w, exmem_f, memwb_w}.
module tb_pipe_hazard_ctrl;

  localparam logic [9:0] V_INIT   = 10'b1_0_0_1_1_1_1_1_1_1;
  localparam logic [9:0] V_RUN    = 10'b0_1_0_1_0_1_0_1_0_1;
  localparam logic [9:0] V_FREEZE = 10'b0_0_0_0_0_0_0_0_0_0;
  localparam logic [9:0] V_BRANCH = 10'b0_1_1_1_1_1_1_1_1_1;
  localparam logic [9:0] V_LDUSE  = 10'b0_0_0_0_0_1_1_1_0_1;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  pipe_hazard_ctrl_if bus ();

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_o, perf_flush_o, perf_wait_o;
`endif

  pipe_hazard_ctrl #(.INIT_CYCLES(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
`ifdef PIPE_HAZARD_PERF_EN
    .perf_stall_o (perf_stall_o),
    .perf_flush_o (perf_flush_o),
    .perf_wait_o  (perf_wait_o),
`endif
    .bus          (bus)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [9:0] outs();
    return {bus.ctrl_busy_o, bus.pc_write_o, bus.pc_sel_o,
            bus.ifid_write_o, bus.ifid_flush_o, bus.idex_write_o, bus.idex_flush_o,
            bus.exmem_write_o, bus.exmem_flush_o, bus.memwb_write_o};
  endfunction

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Sample mid-cycle, then advance to just after the next posedge.
  task automatic apply(input string tag, input logic [9:0] exp);
    #3;
    check_vec(tag, {22'd0, outs()}, {22'd0, exp});
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_in(input logic rd_ld, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic br, input logic z, input logic busy);
    bus.ex_mem_read_i = rd_ld;
    bus.ex_rd_i       = rd;
    bus.id_rs1_i      = rs1;
    bus.id_rs2_i      = rs2;
    bus.mem_branch_i  = br;
    bus.mem_zero_i    = z;
    bus.dmem_busy_i   = busy;
  endtask

  initial begin
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    apply("reset", V_INIT);
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) apply($sformatf("scrub%0d", i), V_INIT);
    apply("run_after_scrub", V_RUN);

    set_in(1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0);
    apply("lduse_rs2", V_LDUSE);
    set_in(1'b0, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0);
    apply("lduse_cleared", V_RUN);
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    apply("lduse_x0", V_RUN);
    set_in(1'b1, 5'd7, 5'd7, 5'd2, 1'b0, 1'b0, 1'b0);
    apply("lduse_rs1", V_LDUSE);
    set_in(1'b1, 5'd7, 5'd6, 5'd8, 1'b0, 1'b0, 1'b0);
    apply("load_no_dep", V_RUN);

    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    apply("branch_taken", V_BRANCH);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    apply("branch_not_taken", V_RUN);
    set_in(1'b1, 5'd3, 5'd3, 5'd9, 1'b1, 1'b1, 1'b0);
    apply("branch_over_lduse", V_BRANCH);

    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) apply($sformatf("wait%0d", i), V_FREEZE);
    bus.dmem_busy_i = 1'b0;
    apply("branch_after_wait", V_BRANCH);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    apply("run_after_wait", V_RUN);
`ifdef PIPE_HAZARD_PERF_EN
    check_vec("perf_stall", perf_stall_o, 32'd2);
    check_vec("perf_flush", perf_flush_o, 32'd3);
    check_vec("perf_wait",  perf_wait_o,  32'd3);
`endif

    bus.dmem_busy_i = 1'b1;
    apply("wait_before_rst", V_FREEZE);
    rst_i = 1'b1;
    apply("rst_mid_wait", V_INIT);
    rst_i = 1'b0;
    apply("init_after_rst", V_INIT);
`ifdef PIPE_HAZARD_PERF_EN
    check_vec("perf_wait_cleared", perf_wait_o, 32'd0);
    check_vec("perf_flush_cleared", perf_flush_o, 32'd0);
`endif
    for (int i = 1; i < 4; i++) apply($sformatf("rescrub%0d", i), V_INIT);
    apply("busy_after_rescrub", V_FREEZE);
    bus.dmem_busy_i = 1'b0;
    apply("run_after_rescrub", V_RUN);
`ifdef PIPE_HAZARD_PERF_EN
    check_vec("perf_wait_post_init", perf_wait_o, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
